scancode_ascii_decoder: RTL and testbench
=========================================

# scancode_ascii_decoder

Sequential successor to the combinational ASCII converter. It consumes a stream of PS/2 Set 2 keyboard scan-code bytes and tracks make/break prefixes, extended prefixes, Shift state and Caps Lock. Each printable key press is translated to ASCII and buffered in a parametrised show-ahead FIFO with a valid/ready output handshake. It sits between the PS/2 byte receiver and the character consumer (display/UART path).

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), width of fill count
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- code_in  input  8  scan-code byte
- code_valid  input  1  code_in is sampled on a clk edge when this is high; no backpressure
- ascii_out  output  8  head-of-FIFO character; 0x00 when empty
- ascii_valid  output  1  FIFO not empty
- ascii_ready  input  1  consumer pops the head on a clk edge when ascii_valid && ascii_ready
- fifo_count  output  CNT_W  entries currently stored
- overflow  output  1  sticky; a character was dropped because the FIFO was full
- caps_state  output  1  current Caps Lock state; constant 0 when the feature is compiled out

## Operation
- Decoder FSM states: IDLE, BRK (0xF0 seen), EXT (0xE0 seen), EXT_BRK (0xE0 0xF0 seen). Transitions happen only on code_valid.
- IDLE transitions:
  - 0xF0 → BRK
  - 0xE0 → EXT
  - any other byte is a make code, handled below; stay in IDLE
- BRK: the byte is a break code. 0x12 clears shift_l and 0x59 clears shift_r; any other byte is discarded. Return to IDLE.
- EXT: 0xF0 → EXT_BRK; any other byte is discarded → IDLE. No extended key is ever mapped.
- EXT_BRK: discard the byte → IDLE.
- Make-code handling:
  - 0x12 sets shift_l; 0x59 sets shift_r
  - 0x58 toggles caps (only with SCANCODE_CAPS_EN)
  - a mapped code pushes one character
  - an unmapped code pushes nothing
  - repeated make codes (typematic) push one character each
- Mapping uses the US Set 2 layout:
  - letters a–z map to 0x61–0x7A; uppercase is 0x41–0x5A when (shift_l|shift_r) XOR caps
  - digits 0–9 map to 0x30–0x39; Shift and Caps have no effect on digits
  - 0x29 → 0x20 (space), 0x5A → 0x0D (enter), 0x66 → 0x08 (backspace)
- FIFO push, full case: the character is dropped and overflow is set. overflow clears only on rst.
- FIFO push and pop in the same cycle:
  - when full: the pop frees a slot, the push is accepted, and count is unchanged
  - when empty: the push is accepted and there is no pop, because ascii_valid was 0
- FIFO pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- ascii_out and ascii_valid hold stable while ascii_valid && !ascii_ready.

## Timing
- rst takes effect on the clk edge where it is sampled high. After that edge:
  - ascii_out, ascii_valid, fifo_count, overflow and caps_state are all 0
  - FSM is in IDLE, shift_l and shift_r are 0, the FIFO is emptied
  - inputs in the same cycle are ignored
- rst asserted mid-sequence (e.g. after 0xF0) discards the pending prefix. Buffered characters are lost.
- Latency: a mapped make byte sampled at edge N into an empty FIFO gives ascii_valid=1 and the character on ascii_out after edge N.
- Modifier changes apply to the next sampled byte. Shift make at edge N affects a letter sampled at N+1.
- Throughput: one byte in per cycle and one character out per cycle.
- All outputs are registered or driven directly from registers; no combinational path from inputs to outputs.

## Configuration
- SCANCODE_CAPS_EN defined:
  - 0x58 make toggles caps and is pushed as nothing
  - 0x58 break is ignored
  - caps_state reflects the caps register
- SCANCODE_CAPS_EN undefined:
  - no caps register exists, caps_state ties to 0, case depends on Shift alone
  - 0x58 is treated as an unmapped make code
  - prefix handling for 0x58 is unchanged

## Test plan
- Reset, then 0x1C, 0x32, 0x16 with ascii_ready=1 → ascii_out sequence 0x61, 0x62, 0x31; fifo_count returns to 0; overflow=0.
- 0x12, 0x1C, 0xF0, 0x12, 0x1C → outputs 0x41 then 0x61. 0xF0 0x1C alone outputs nothing.
- With SCANCODE_CAPS_EN: 0x58, 0x1C, 0x12, 0x1C → caps_state=1; outputs 0x41 then 0x61 (Shift XOR Caps). Without the macro: outputs 0x61, 0x41 and caps_state stays 0.
- ascii_ready=0 with DEPTH=8: push 9 mapped keys → fifo_count=8, overflow=1, and ascii_out holds the first character. Then ready=1 with a simultaneous push while full → count stays 8 and the pushed character is accepted.
- 0xE0, 0x1C, 0xE0, 0xF0, 0x1C, 0x07 (unmapped) → no pushes and FSM ends in IDLE. A following 0x29 outputs 0x20.
- Drive 0xF0, assert rst for one cycle, then 0x1C → output 0x61, because the prefix was discarded and the FIFO was cleared by rst.

Source files
------------

// File: rtl/scancode_ascii_decoder.sv
// scancode_ascii_decoder: PS/2 Set 2 scan-code byte stream -> ASCII characters.
// Tracks break (0xF0) and extended (0xE0) prefixes plus left/right Shift,
// maps printable make codes (US layout) and buffers the characters in a
// show-ahead FIFO with a valid/ready output handshake.
// Optional feature macro: SCANCODE_CAPS_EN (Caps Lock toggle on 0x58 make).
module scancode_ascii_decoder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  output logic [7:0]       ascii_out,
  output logic             ascii_valid,
  input  logic             ascii_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             caps_state
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t           r_state, w_next;
  logic             r_shift_l, r_shift_r;
  logic             w_set_l, w_set_r, w_clr_l, w_clr_r;
  logic             w_push, w_push_ok, w_pop, w_full, w_upper, w_caps;
  logic [7:0]       w_char, w_lower;
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  // Lower-case / digit / control character for a make code; 0 means unmapped.
  function automatic logic [7:0] f_map(input logic [7:0] c);
    case (c)
      8'h1C: f_map = 8'h61; 8'h32: f_map = 8'h62; 8'h21: f_map = 8'h63;
      8'h23: f_map = 8'h64; 8'h24: f_map = 8'h65; 8'h2B: f_map = 8'h66;
      8'h34: f_map = 8'h67; 8'h33: f_map = 8'h68; 8'h43: f_map = 8'h69;
      8'h3B: f_map = 8'h6A; 8'h42: f_map = 8'h6B; 8'h4B: f_map = 8'h6C;
      8'h3A: f_map = 8'h6D; 8'h31: f_map = 8'h6E; 8'h44: f_map = 8'h6F;
      8'h4D: f_map = 8'h70; 8'h15: f_map = 8'h71; 8'h2D: f_map = 8'h72;
      8'h1B: f_map = 8'h73; 8'h2C: f_map = 8'h74; 8'h3C: f_map = 8'h75;
      8'h2A: f_map = 8'h76; 8'h1D: f_map = 8'h77; 8'h22: f_map = 8'h78;
      8'h35: f_map = 8'h79; 8'h1A: f_map = 8'h7A;
      8'h45: f_map = 8'h30; 8'h16: f_map = 8'h31; 8'h1E: f_map = 8'h32;
      8'h26: f_map = 8'h33; 8'h25: f_map = 8'h34; 8'h2E: f_map = 8'h35;
      8'h36: f_map = 8'h36; 8'h3D: f_map = 8'h37; 8'h3E: f_map = 8'h38;
      8'h46: f_map = 8'h39;
      8'h29: f_map = 8'h20; 8'h5A: f_map = 8'h0D; 8'h66: f_map = 8'h08;
      default: f_map = 8'h00;
    endcase
  endfunction

`ifdef SCANCODE_CAPS_EN
  logic r_caps, w_tog_caps;
  // Caps Lock register toggles on each 0x58 make.
  always_ff @(posedge clk) begin
    if (rst)             r_caps <= 1'b0;
    else if (w_tog_caps) r_caps <= ~r_caps;
  end
  assign w_caps     = r_caps;
`else
  assign w_caps     = 1'b0;
`endif
  assign caps_state = w_caps;

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Prefix tracking: next state, advancing only on valid bytes.
  always_comb begin
    w_next = r_state;
    if (code_valid) begin
      case (r_state)
        IDLE:    if (code_in == 8'hF0)      w_next = BRK;
                 else if (code_in == 8'hE0) w_next = EXT;
        EXT:     w_next = (code_in == 8'hF0) ? EXT_BRK : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Per-byte actions: modifier updates and character push.
  always_comb begin
    w_set_l = 1'b0; w_set_r = 1'b0; w_clr_l = 1'b0; w_clr_r = 1'b0;
`ifdef SCANCODE_CAPS_EN
    w_tog_caps = 1'b0;
`endif
    w_push  = 1'b0;
    w_lower = f_map(code_in);
    if (code_valid && r_state == IDLE && code_in != 8'hF0 && code_in != 8'hE0) begin
      w_set_l = (code_in == 8'h12);
      w_set_r = (code_in == 8'h59);
`ifdef SCANCODE_CAPS_EN
      w_tog_caps = (code_in == 8'h58);
`endif
      w_push  = (w_lower != 8'h00);
    end
    if (code_valid && r_state == BRK) begin
      w_clr_l = (code_in == 8'h12);
      w_clr_r = (code_in == 8'h59);
    end
  end

  // Letters flip case when exactly one of Shift / Caps is active.
  assign w_upper = (r_shift_l | r_shift_r) ^ w_caps;
  assign w_char  = (w_upper && w_lower >= 8'h61 && w_lower <= 8'h7A) ? (w_lower & 8'hDF) : w_lower;

  // Shift registers: make sets, break clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
    end else begin
      if (w_set_l) r_shift_l <= 1'b1; else if (w_clr_l) r_shift_l <= 1'b0;
      if (w_set_r) r_shift_r <= 1'b1; else if (w_clr_r) r_shift_r <= 1'b0;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop     = ascii_valid && ascii_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);

  // FIFO storage; contents need no reset because the count gates the output.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_wr_ptr] <= w_char;
  end

  // FIFO pointers, fill count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign ascii_valid = (r_count != '0);
  assign ascii_out   = ascii_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;
endmodule

// File: tb/tb_scancode_ascii_decoder.sv
// Directed bench for scancode_ascii_decoder: expected characters are queued
// as bytes are driven and checked as the consumer pops them.
module tb_scancode_ascii_decoder;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       code_in = 8'h00;
  logic             code_valid = 1'b0;
  logic [7:0]       ascii_out;
  logic             ascii_valid;
  logic             ascii_ready = 1'b1;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic             caps_state;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

`ifdef SCANCODE_CAPS_EN
  localparam bit CAPS = 1'b1;
`else
  localparam bit CAPS = 1'b0;
`endif

  scancode_ascii_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .ascii_out(ascii_out), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .fifo_count(fifo_count), .overflow(overflow), .caps_state(caps_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each accepted pop must match the oldest expected character.
  always @(negedge clk) begin
    if (!rst && ascii_valid && ascii_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_char: observed %h expected none", ascii_out);
      end else begin
        chk("pop_char", ascii_out, exp_q.pop_front());
      end
    end
  end

  // One byte per cycle; returns 1 time unit after the sampling edge.
  task automatic key(input logic [7:0] c, input logic [7:0] e, input bit has_e);
    code_in = c;
    code_valid = 1'b1;
    if (has_e) exp_q.push_back(e);
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // reset
    idle(2);
    rst = 1'b0;
    chk("rst_valid", {7'b0, ascii_valid}, 8'h00);
    chk("rst_out", ascii_out, 8'h00);
    chk("rst_count", 8'(fifo_count), 8'h00);
    chk("rst_ovf", {7'b0, overflow}, 8'h00);
    chk("rst_caps", {7'b0, caps_state}, 8'h00);

    // basic letters and digit, single-cycle latency
    key(8'h1C, 8'h61, 1);
    chk("latency_valid", {7'b0, ascii_valid}, 8'h01);
    chk("latency_out", ascii_out, 8'h61);
    key(8'h32, 8'h62, 1);
    key(8'h16, 8'h31, 1);
    idle(4);
    chk("drain_count", 8'(fifo_count), 8'h00);
    chk("drain_ovf", {7'b0, overflow}, 8'h00);
    chk("q_empty1", 8'(exp_q.size()), 8'h00);

    // shift make/break, bare break outputs nothing
    key(8'h12, 8'h00, 0);
    key(8'h1C, 8'h41, 1);
    key(8'hF0, 8'h00, 0);
    key(8'h12, 8'h00, 0);
    key(8'h1C, 8'h61, 1);
    key(8'hF0, 8'h00, 0);
    key(8'h1C, 8'h00, 0);
    key(8'h59, 8'h00, 0);      // right shift, digits unaffected
    key(8'h45, 8'h30, 1);
    key(8'h2C, 8'h54, 1);
    key(8'hF0, 8'h00, 0);
    key(8'h59, 8'h00, 0);
    idle(4);
    chk("q_empty2", 8'(exp_q.size()), 8'h00);

    // caps lock (or unmapped 0x58 without the feature)
    key(8'h58, 8'h00, 0);
    key(8'h1C, CAPS ? 8'h41 : 8'h61, 1);
    key(8'h12, 8'h00, 0);
    key(8'h1C, CAPS ? 8'h61 : 8'h41, 1);
    chk("caps_on", {7'b0, caps_state}, {7'b0, CAPS});
    key(8'hF0, 8'h00, 0);
    key(8'h58, 8'h00, 0);
    chk("caps_brk", {7'b0, caps_state}, {7'b0, CAPS});
    key(8'h58, 8'h00, 0);
    key(8'hF0, 8'h00, 0);
    key(8'h12, 8'h00, 0);
    chk("caps_off", {7'b0, caps_state}, 8'h00);
    key(8'h1C, 8'h61, 1);
    idle(4);
    chk("q_empty3", 8'(exp_q.size()), 8'h00);

    // fill to overflow with consumer stalled
    ascii_ready = 1'b0;
    key(8'h1C, 8'h61, 1); key(8'h32, 8'h62, 1); key(8'h21, 8'h63, 1);
    key(8'h23, 8'h64, 1); key(8'h24, 8'h65, 1); key(8'h2B, 8'h66, 1);
    key(8'h34, 8'h67, 1); key(8'h33, 8'h68, 1);
    chk("full_no_ovf", {7'b0, overflow}, 8'h00);
    key(8'h43, 8'h69, 0);      // dropped
    chk("full_count", 8'(fifo_count), 8'h08);
    chk("full_ovf", {7'b0, overflow}, 8'h01);
    idle(3);
    chk("hold_out", ascii_out, 8'h61);
    chk("hold_valid", {7'b0, ascii_valid}, 8'h01);
    ascii_ready = 1'b1;
    key(8'h3B, 8'h6A, 1);      // push + pop while full
    chk("full_pushpop_count", 8'(fifo_count), 8'h08);
    idle(12);
    chk("drain2_count", 8'(fifo_count), 8'h00);
    chk("ovf_sticky", {7'b0, overflow}, 8'h01);
    chk("q_empty4", 8'(exp_q.size()), 8'h00);

    // extended prefixes never map
    key(8'hE0, 8'h00, 0); key(8'h1C, 8'h00, 0);
    key(8'hE0, 8'h00, 0); key(8'hF0, 8'h00, 0); key(8'h1C, 8'h00, 0);
    key(8'h07, 8'h00, 0);
    chk("ext_none", {7'b0, ascii_valid}, 8'h00);
    key(8'h29, 8'h20, 1);
    key(8'h5A, 8'h0D, 1);
    key(8'h66, 8'h08, 1);
    idle(4);
    chk("q_empty5", 8'(exp_q.size()), 8'h00);

    // reset mid-prefix with buffered data
    ascii_ready = 1'b0;
    key(8'h1C, 8'h00, 0);      // buffered, lost on reset
    key(8'hF0, 8'h00, 0);
    rst = 1'b1;
    code_in = 8'h32; code_valid = 1'b1;  // ignored during reset
    idle(1);
    rst = 1'b0; code_valid = 1'b0;
    chk("rst2_count", 8'(fifo_count), 8'h00);
    chk("rst2_valid", {7'b0, ascii_valid}, 8'h00);
    chk("rst2_ovf", {7'b0, overflow}, 8'h00);
    ascii_ready = 1'b1;
    key(8'h1C, 8'h61, 1);
    idle(4);
    chk("q_empty6", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
